multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the RV32I core. It sequences fetch, decode, execute, memory and write-back around the instruction field decoder, which supplies opcode, func3 and func7. It drives all datapath enables and selects, and handshakes with instruction and data memory. It halts on illegal instructions, ECALL/EBREAK, or a bus timeout.

---
 rtl/riscv_ctrl_pkg.sv | 77 +++++++
 rtl/alu_op_decode.sv | 60 ++++++
 rtl/multicycle_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control path: opcodes, FSM states,
// datapath select codes and the coarse instruction class.
package riscv_ctrl_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_op_t;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef enum logic [3:0] {
        OC_NONE, OC_R, OC_I, OC_LOAD, OC_STORE, OC_BRANCH, OC_JAL,
        OC_JALR, OC_LUI, OC_AUIPC, OC_FENCE, OC_SYSTEM, OC_ILLEGAL
    } op_class_t;

    function automatic op_class_t classify(input logic [6:0] opc);
        case (opc)
            OPC_OP:     return OC_R;
            OPC_OP_IMM: return OC_I;
            OPC_LOAD:   return OC_LOAD;
            OPC_STORE:  return OC_STORE;
            OPC_BRANCH: return OC_BRANCH;
            OPC_JAL:    return OC_JAL;
            OPC_JALR:   return OC_JALR;
            OPC_LUI:    return OC_LUI;
            OPC_AUIPC:  return OC_AUIPC;
            OPC_FENCE:  return OC_FENCE;
            OPC_SYSTEM: return OC_SYSTEM;
            default:    return OC_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Maps instruction class plus func3/func7 to an ALU operation and flags
// func3/func7 combinations that are not valid RV32I encodings.
module alu_op_decode
    import riscv_ctrl_pkg::*;
(
    input  op_class_t   op_class,
    input  logic [2:0]  func3,
    input  logic [6:0]  func7,
    output alu_op_t     alu_op,
    output logic        func_legal
);

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // func3 table shared by register and immediate arithmetic
    function automatic alu_op_t arith(input logic [2:0] f3, input logic alt_add,
                                      input logic alt_shift);
        case (f3)
            3'b000:  return alt_add ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt_shift ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        alu_op     = ALU_ADD;
        func_legal = 1'b1;
        case (op_class)
            OC_R: begin
                alu_op     = arith(func3, func7[5], func7[5]);
                func_legal = (func7 == F7_BASE) ||
                             ((func7 == F7_ALT) && ((func3 == 3'b000) || (func3 == 3'b101)));
            end
            OC_I: begin
                alu_op = arith(func3, 1'b0, func7[5]);
                if (func3 == 3'b001)
                    func_legal = (func7 == F7_BASE);
                else if (func3 == 3'b101)
                    func_legal = (func7 == F7_BASE) || (func7 == F7_ALT);
            end
            OC_LOAD:   func_legal = func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            OC_STORE:  func_legal = func3 inside {3'b000, 3'b001, 3'b010};
            OC_BRANCH: begin
                alu_op     = ALU_SUB;
                func_legal = !(func3 inside {3'b010, 3'b011});
            end
            OC_LUI:     alu_op = ALU_PASS_B;
            OC_NONE,
            OC_ILLEGAL: func_legal = 1'b0;
            default:    alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb sequencing, datapath
// selects, memory handshakes with a bounded wait, and sticky halt causes.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 200,
    parameter int unsigned TO_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    input  logic       branch_taken,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic [3:0] alu_op,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic [2:0] imm_sel,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       illegal,
    output logic       bus_timeout,
    output logic       halted,
    output logic [2:0] state
);

    state_t          state_q, state_d;
    op_class_t       op_class_q, op_class_d;
    logic [TO_W-1:0] wait_q, wait_d;
    logic            illegal_q, illegal_d;
    logic            timeout_q, timeout_d;

    op_class_t dec_class;
    op_class_t alu_class;
    alu_op_t   dec_alu_op;
    logic      func_legal;
    logic      wait_last;

    assign dec_class = classify(opcode);
    // The class register is not loaded until the end of DECODE, so legality there uses the live opcode
    assign alu_class = (state_q == ST_DECODE) ? dec_class : op_class_q;
    assign wait_last = (wait_q == TO_W'(TIMEOUT - 1));

    alu_op_decode u_alu_op_decode (
        .op_class   (alu_class),
        .func3      (func3),
        .func7      (func7),
        .alu_op     (dec_alu_op),
        .func_legal (func_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_class_q <= OC_NONE;
            wait_q     <= '0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_class_q <= op_class_d;
            wait_q     <= wait_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_class_d = op_class_q;
        wait_d     = '0;
        illegal_d  = illegal_q;
        timeout_d  = timeout_q;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = PC_PLUS4;
        alu_op     = 4'(ALU_ADD);
        alu_src_a  = 1'b0;
        alu_src_b  = 1'b0;
        imm_sel    = IMM_I;
        rf_we      = 1'b0;
        wb_sel     = WB_ALU;
        halted     = 1'b0;

        case (state_q)
            ST_IDLE: state_d = ST_FETCH;

            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (wait_last) begin
                    timeout_d = 1'b1;
                    state_d   = ST_HALT;
                end else begin
                    wait_d = wait_q + TO_W'(1);
                end
            end

            ST_DECODE: begin
                op_class_d = dec_class;
                if ((dec_class == OC_ILLEGAL) || !func_legal) begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end else if (dec_class == OC_SYSTEM) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                alu_op  = 4'(dec_alu_op);
                state_d = ST_WB;
                case (op_class_q)
                    OC_R:     alu_src_b = 1'b0;
                    OC_I: begin
                        alu_src_b = 1'b1;
                        imm_sel   = IMM_I;
                    end
                    OC_LUI:   imm_sel = IMM_U;
                    OC_AUIPC: begin
                        alu_src_a = 1'b1;
                        imm_sel   = IMM_U;
                    end
                    OC_LOAD: begin
                        alu_src_b = 1'b1;
                        imm_sel   = IMM_I;
                        state_d   = ST_MEM;
                    end
                    OC_STORE: begin
                        alu_src_b = 1'b1;
                        imm_sel   = IMM_S;
                        state_d   = ST_MEM;
                    end
                    OC_BRANCH: begin
                        imm_sel = IMM_B;
                        pc_we   = 1'b1;
                        pc_sel  = branch_taken ? PC_BRANCH : PC_PLUS4;
                        state_d = ST_FETCH;
                    end
                    OC_JAL:   imm_sel = IMM_J;
                    OC_JALR: begin
                        imm_sel   = IMM_I;
                        alu_src_b = 1'b1;
                    end
                    OC_FENCE: begin
                        pc_we   = 1'b1;
                        state_d = ST_FETCH;
                    end
                    default:  state_d = ST_HALT;
                endcase
            end

            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op_class_q == OC_STORE);
                if (dmem_ready) begin
                    if (op_class_q == OC_STORE) begin
                        pc_we   = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (wait_last) begin
                    timeout_d = 1'b1;
                    state_d   = ST_HALT;
                end else begin
                    wait_d = wait_q + TO_W'(1);
                end
            end

            ST_WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                state_d = ST_FETCH;
                if (op_class_q == OC_LOAD) begin
                    wb_sel = WB_MEM;
                end else if ((op_class_q == OC_JAL) || (op_class_q == OC_JALR)) begin
                    wb_sel = WB_PC4;
                    pc_sel = PC_JUMP;
                end
            end

            ST_HALT: halted = 1'b1;

            default: state_d = ST_IDLE;
        endcase
    end

    assign illegal     = illegal_q;
    assign bus_timeout = timeout_q;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-instruction expectations are queued
// when an instruction is presented and retired against the DUT's pc_we cycle.
module tb_multicycle_ctrl;
    import riscv_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] func3 = '0;
    logic [6:0] func7 = '0;
    logic       branch_taken = 1'b0;
    logic       imem_ready = 1'b0;
    logic       dmem_ready = 1'b0;
    logic       imem_req, dmem_req, dmem_we, ir_we, pc_we;
    logic [1:0] pc_sel;
    logic [3:0] alu_op;
    logic       alu_src_a, alu_src_b;
    logic [2:0] imm_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       illegal, bus_timeout, halted;
    logic [2:0] state;

    multicycle_ctrl #(.TIMEOUT(8), .TO_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3), .func7(func7),
        .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .alu_op(alu_op), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .imm_sel(imm_sel), .rf_we(rf_we), .wb_sel(wb_sel),
        .illegal(illegal), .bus_timeout(bus_timeout), .halted(halted), .state(state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       tk;
        int         mw;
        bit         chk_alu;
        logic [3:0] alu;
        bit         chk_imm;
        logic [2:0] imm;
        logic [1:0] psel;
        logic       rf;
        logic [1:0] wsel;
        int         lat;
        int         memc;
    } exp_t;

    exp_t sb[$];

    function automatic exp_t mk(logic [6:0] op, logic [2:0] f3, logic [6:0] f7, logic tk,
                                int mw, bit ca, logic [3:0] alu, bit ci, logic [2:0] imm,
                                logic [1:0] psel, logic rf, logic [1:0] wsel, int lat, int memc);
        exp_t e;
        e.op = op; e.f3 = f3; e.f7 = f7; e.tk = tk; e.mw = mw;
        e.chk_alu = ca; e.alu = alu; e.chk_imm = ci; e.imm = imm;
        e.psel = psel; e.rf = rf; e.wsel = wsel; e.lat = lat; e.memc = memc;
        return e;
    endfunction

    task automatic do_reset;
        logic [26:0] outs;
        rst_n = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
        opcode = '0; func3 = '0; func7 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        outs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_op, alu_src_a,
                alu_src_b, imm_sel, rf_we, wb_sel, illegal, bus_timeout, halted, state};
        total++;
        if (outs !== 27'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (state !== 3'd0 || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_release: state=%0d imem_req=%b expected 0/0", state, imem_req);
        end
        @(posedge clk); #1;
        total++;
        if (state !== 3'd1 || imem_req !== 1'b1) begin
            bad++;
            $display("FAIL first_fetch: state=%0d imem_req=%b expected 1/1", state, imem_req);
        end
    endtask

    task automatic test_reset;
        do_reset();
    endtask

    // Runs one instruction from FETCH to its pc_we cycle; leaves DUT back in FETCH
    task automatic run_instr(input exp_t e, input int idx);
        exp_t x;
        int   cyc = 0;
        int   mcnt = 0;
        int   reqc = 0;
        bit   done = 0;
        sb.push_back(e);
        opcode = e.op; func3 = e.f3; func7 = e.f7; branch_taken = e.tk;
        imem_ready = 1'b1;
        while (!done && cyc < 30) begin
            if (state == 3'd4) begin
                dmem_ready = (mcnt == e.mw);
                mcnt++;
            end else begin
                dmem_ready = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                total++;
                if (ir_we !== 1'b1 || imem_req !== 1'b1) begin
                    bad++;
                    $display("FAIL fetch_irwe[%0d]: ir_we=%b imem_req=%b expected 1/1", idx, ir_we, imem_req);
                end
            end
            if (dmem_req === 1'b1) begin
                reqc++;
                total++;
                if (dmem_we !== (e.op == OPC_STORE)) begin
                    bad++;
                    $display("FAIL dmem_we[%0d]: got %b expected %b", idx, dmem_we, e.op == OPC_STORE);
                end
            end
            if (state == 3'd3 && sb.size() > 0) begin
                if (sb[0].chk_alu) begin
                    total++;
                    if (alu_op !== sb[0].alu) begin
                        bad++;
                        $display("FAIL exec_alu_op[%0d]: got %0d expected %0d", idx, alu_op, sb[0].alu);
                    end
                end
                if (sb[0].chk_imm) begin
                    total++;
                    if (imm_sel !== sb[0].imm) begin
                        bad++;
                        $display("FAIL exec_imm_sel[%0d]: got %0d expected %0d", idx, imm_sel, sb[0].imm);
                    end
                end
            end
            if (pc_we === 1'b1 && sb.size() > 0) begin
                x = sb.pop_front();
                done = 1;
                total++;
                if (pc_sel !== x.psel || rf_we !== x.rf) begin
                    bad++;
                    $display("FAIL retire_ctrl[%0d]: pc_sel=%0d rf_we=%b expected %0d/%b", idx, pc_sel, rf_we, x.psel, x.rf);
                end
                if (x.rf) begin
                    total++;
                    if (wb_sel !== x.wsel) begin
                        bad++;
                        $display("FAIL retire_wb_sel[%0d]: got %0d expected %0d", idx, wb_sel, x.wsel);
                    end
                end
                total++;
                if (cyc != x.lat) begin
                    bad++;
                    $display("FAIL latency[%0d]: got %0d expected %0d", idx, cyc, x.lat);
                end
            end
            @(posedge clk); #1;
        end
        dmem_ready = 1'b0;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL retire_seen[%0d]: got none within 30 cycles expected pc_we", idx);
            sb.delete();
        end
        total++;
        if (reqc != e.memc) begin
            bad++;
            $display("FAIL dmem_req_cycles[%0d]: got %0d expected %0d", idx, reqc, e.memc);
        end
        total++;
        if ({illegal, bus_timeout, halted} !== 3'b000 || state !== 3'd1) begin
            bad++;
            $display("FAIL back_in_fetch[%0d]: flags=%b state=%0d expected 000/1", idx, {illegal, bus_timeout, halted}, state);
        end
    endtask

    // Legal instructions issued back to back without reset in between
    task automatic test_back_to_back;
        exp_t tbl[$];
        do_reset();
        tbl.push_back(mk(OPC_OP,     3'b000, 7'b0000000, 0, 0, 1, 4'd0,  0, 3'd0, 2'd0, 1, 2'd0, 4, 0));
        tbl.push_back(mk(OPC_OP,     3'b000, 7'b0100000, 0, 0, 1, 4'd1,  0, 3'd0, 2'd0, 1, 2'd0, 4, 0));
        tbl.push_back(mk(OPC_OP,     3'b101, 7'b0100000, 0, 0, 1, 4'd7,  0, 3'd0, 2'd0, 1, 2'd0, 4, 0));
        tbl.push_back(mk(OPC_OP,     3'b011, 7'b0000000, 0, 0, 1, 4'd4,  0, 3'd0, 2'd0, 1, 2'd0, 4, 0));
        tbl.push_back(mk(OPC_OP,     3'b111, 7'b0000000, 0, 0, 1, 4'd9,  0, 3'd0, 2'd0, 1, 2'd0, 4, 0));
        tbl.push_back(mk(OPC_OP_IMM, 3'b000, 7'b0100000, 0, 0, 1, 4'd0,  1, 3'd0, 2'd0, 1, 2'd0, 4, 0));
        tbl.push_back(mk(OPC_OP_IMM, 3'b101, 7'b0100000, 0, 0, 1, 4'd7,  1, 3'd0, 2'd0, 1, 2'd0, 4, 0));
        tbl.push_back(mk(OPC_OP_IMM, 3'b001, 7'b0000000, 0, 0, 1, 4'd2,  1, 3'd0, 2'd0, 1, 2'd0, 4, 0));
        tbl.push_back(mk(OPC_OP_IMM, 3'b110, 7'b0000000, 0, 0, 1, 4'd8,  1, 3'd0, 2'd0, 1, 2'd0, 4, 0));
        tbl.push_back(mk(OPC_LUI,    3'b000, 7'b0000000, 0, 0, 1, 4'd10, 1, 3'd3, 2'd0, 1, 2'd0, 4, 0));
        tbl.push_back(mk(OPC_AUIPC,  3'b000, 7'b0000000, 0, 0, 1, 4'd0,  1, 3'd3, 2'd0, 1, 2'd0, 4, 0));
        tbl.push_back(mk(OPC_LOAD,   3'b010, 7'b0000000, 0, 3, 1, 4'd0,  1, 3'd0, 2'd0, 1, 2'd1, 8, 4));
        tbl.push_back(mk(OPC_LOAD,   3'b100, 7'b0000000, 0, 0, 1, 4'd0,  1, 3'd0, 2'd0, 1, 2'd1, 5, 1));
        tbl.push_back(mk(OPC_STORE,  3'b010, 7'b0000000, 0, 0, 1, 4'd0,  1, 3'd1, 2'd0, 0, 2'd0, 4, 1));
        tbl.push_back(mk(OPC_STORE,  3'b000, 7'b0000000, 0, 2, 1, 4'd0,  1, 3'd1, 2'd0, 0, 2'd0, 6, 3));
        tbl.push_back(mk(OPC_BRANCH, 3'b000, 7'b0000000, 1, 0, 1, 4'd1,  1, 3'd2, 2'd1, 0, 2'd0, 3, 0));
        tbl.push_back(mk(OPC_BRANCH, 3'b000, 7'b0000000, 0, 0, 1, 4'd1,  1, 3'd2, 2'd0, 0, 2'd0, 3, 0));
        tbl.push_back(mk(OPC_BRANCH, 3'b111, 7'b0000000, 1, 0, 1, 4'd1,  1, 3'd2, 2'd1, 0, 2'd0, 3, 0));
        tbl.push_back(mk(OPC_JAL,    3'b000, 7'b0000000, 0, 0, 0, 4'd0,  1, 3'd4, 2'd2, 1, 2'd2, 4, 0));
        tbl.push_back(mk(OPC_JALR,   3'b000, 7'b0000000, 0, 0, 0, 4'd0,  1, 3'd0, 2'd2, 1, 2'd2, 4, 0));
        tbl.push_back(mk(OPC_FENCE,  3'b000, 7'b0000000, 0, 0, 0, 4'd0,  0, 3'd0, 2'd0, 0, 2'd0, 3, 0));
        foreach (tbl[i]) run_instr(tbl[i], i);
    endtask

    // Illegal encodings and SYSTEM must stop the core for good
    task automatic test_illegal;
        logic [6:0] ops[8] = '{OPC_OP, 7'b1111111, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_SYSTEM};
        logic [2:0] f3s[8] = '{3'b000, 3'b000, 3'b010, 3'b011, 3'b100, 3'b001, 3'b001, 3'b000};
        logic [6:0] f7s[8] = '{7'b0000001, 7'b0, 7'b0, 7'b0, 7'b0, 7'b0100000, 7'b0100000, 7'b0};
        bit         ills[8] = '{1, 1, 1, 1, 1, 1, 1, 0};
        for (int k = 0; k < 8; k++) begin
            do_reset();
            opcode = ops[k]; func3 = f3s[k]; func7 = f7s[k]; imem_ready = 1'b1;
            repeat (2) @(posedge clk);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                total++;
                if (halted !== 1'b1 || imem_req !== 1'b0 || state !== 3'd6 || illegal !== ills[k]) begin
                    bad++;
                    $display("FAIL halt_case[%0d.%0d]: halted=%b imem_req=%b state=%0d illegal=%b expected 1/0/6/%b",
                             k, c, halted, imem_req, state, illegal, ills[k]);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    // Wait-counter boundary on both memory ports
    task automatic test_timeout;
        int n;
        do_reset();
        opcode = OPC_OP; func3 = 3'b000; func7 = 7'b0;
        n = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (halted === 1'b1) break;
            if (imem_req === 1'b1) n++;
            @(posedge clk); #1;
        end
        total++;
        if (n != 8 || bus_timeout !== 1'b1 || illegal !== 1'b0 || halted !== 1'b1) begin
            bad++;
            $display("FAIL imem_timeout: fetch_cycles=%0d bus_timeout=%b halted=%b expected 8/1/1", n, bus_timeout, halted);
        end

        do_reset();
        opcode = OPC_OP; func3 = 3'b000; func7 = 7'b0;
        for (int c = 0; c < 8; c++) begin
            imem_ready = (c == 7);
            @(negedge clk);
            if (c == 7) begin
                total++;
                if (ir_we !== 1'b1) begin
                    bad++;
                    $display("FAIL late_ready_irwe: got %b expected 1", ir_we);
                end
            end
            @(posedge clk); #1;
        end
        total++;
        if (state !== 3'd2 || bus_timeout !== 1'b0) begin
            bad++;
            $display("FAIL late_ready_decode: state=%0d bus_timeout=%b expected 2/0", state, bus_timeout);
        end

        do_reset();
        opcode = OPC_LOAD; func3 = 3'b010; func7 = 7'b0; imem_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (halted === 1'b1) break;
            if (dmem_req === 1'b1) n++;
            @(posedge clk); #1;
        end
        total++;
        if (n != 8 || bus_timeout !== 1'b1 || halted !== 1'b1) begin
            bad++;
            $display("FAIL dmem_timeout: mem_cycles=%0d bus_timeout=%b halted=%b expected 8/1/1", n, bus_timeout, halted);
        end
    endtask

    // Asynchronous reset while a load is waiting on data memory
    task automatic test_reset_mid_mem;
        int c;
        do_reset();
        opcode = OPC_LOAD; func3 = 3'b010; func7 = 7'b0; imem_ready = 1'b1; dmem_ready = 1'b0;
        c = 0;
        while (state !== 3'd4 && c < 10) begin
            @(posedge clk); #1;
            c++;
        end
        #1;
        total++;
        if (dmem_req !== 1'b1) begin
            bad++;
            $display("FAIL mem_reached: dmem_req=%b state=%0d expected 1/4", dmem_req, state);
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (dmem_req !== 1'b0 || state !== 3'd0 || {illegal, bus_timeout, halted} !== 3'b000) begin
            bad++;
            $display("FAIL async_reset_mem: dmem_req=%b state=%0d flags=%b expected 0/0/000",
                     dmem_req, state, {illegal, bus_timeout, halted});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (state !== 3'd1 || imem_req !== 1'b1) begin
            bad++;
            $display("FAIL refetch_after_reset: state=%0d imem_req=%b expected 1/1", state, imem_req);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1);
    end

endmodule
